// File: rtl/hash_batch_queue.sv
`default_nettype none
// ============================================================================
// Module   : hash_batch_queue
// Brief    : Circular queue of hash-issue batches. A match-engine lane looks
//            up any buffered position with one-cycle latency. Batches retire
//            in order once the lane's request address moves past them.
// Revision : 1.0 - initial release
// ============================================================================
module hash_batch_queue #(
  parameter int HASH_ISSUE_WIDTH = 4,
  parameter int ROW_SIZE         = 8,
  parameter int ADDR_WIDTH       = 32,
  parameter int DEPTH            = 4
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            flush,
  input  logic                                            input_valid,
  input  logic [ADDR_WIDTH-1:0]                           input_head_addr,
  input  logic [HASH_ISSUE_WIDTH*ROW_SIZE-1:0]            input_valid_array,
  input  logic [HASH_ISSUE_WIDTH*ROW_SIZE*ADDR_WIDTH-1:0] input_history_addr_array,
  output logic                                            input_ready,
  input  logic                                            read_req_valid,
  input  logic [ADDR_WIDTH-1:0]                           read_req_addr,
  output logic                                            read_resp_valid,
  output logic                                            read_resp_miss,
  output logic [ADDR_WIDTH-1:0]                           read_resp_addr,
  output logic [ROW_SIZE-1:0]                             read_valid_array,
  output logic [ROW_SIZE*ADDR_WIDTH-1:0]                  read_history_addr_array,
  output logic [$clog2(DEPTH):0]                          occupancy
);

  localparam int c_ptr_w  = $clog2(DEPTH);
  localparam int c_cnt_w  = c_ptr_w + 1;
  localparam int c_pos_w  = $clog2(HASH_ISSUE_WIDTH);
  localparam int c_row_w  = ROW_SIZE * ADDR_WIDTH;
  localparam int c_vld_w  = HASH_ISSUE_WIDTH * ROW_SIZE;
  localparam int c_hist_w = HASH_ISSUE_WIDTH * c_row_w;

  // Batch storage; contents are only meaningful for occupied slots.
  logic [ADDR_WIDTH-1:0] head_q [DEPTH];
  logic [c_vld_w-1:0]    vld_q  [DEPTH];
  logic [c_hist_w-1:0]   hist_q [DEPTH];

  logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_cnt_w-1:0] count_q,  count_d;

  logic                  resp_valid_q;
  logic                  resp_miss_q;
  logic [ADDR_WIDTH-1:0] resp_addr_q;
  logic [ROW_SIZE-1:0]   resp_vld_q;
  logic [c_row_w-1:0]    resp_hist_q;

  logic                  w_nonempty;
  logic [ADDR_WIDTH-1:0] w_oldest_head;
  logic [ADDR_WIDTH:0]   w_oldest_end;
  logic                  w_stale;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_resp;

  logic [DEPTH-1:0]      w_hit_vec;
  logic [ROW_SIZE-1:0]   w_sel_vld  [DEPTH];
  logic [c_row_w-1:0]    w_sel_hist [DEPTH];
  logic                  w_hit;
  logic [ROW_SIZE-1:0]   w_hit_vld;
  logic [c_row_w-1:0]    w_hit_hist;

  assign w_nonempty    = (count_q != '0);
  assign w_oldest_head = head_q[rd_ptr_q];
  // Sum taken one bit wider so a batch ending at the top of the space compares correctly.
  assign w_oldest_end  = {1'b0, w_oldest_head} + (ADDR_WIDTH+1)'(HASH_ISSUE_WIDTH);
  assign w_stale       = read_req_valid && w_nonempty && (read_req_addr < w_oldest_head);
  assign w_pop         = read_req_valid && w_nonempty && ({1'b0, read_req_addr} >= w_oldest_end);
  // A full queue can still take a batch when the oldest one retires this cycle.
  assign input_ready   = !rst && !flush && ((count_q < c_cnt_w'(DEPTH)) || w_pop);
  assign w_push        = input_valid && input_ready;

  // Per-entry hit detection and slice extraction.
  for (genvar e = 0; e < DEPTH; e++) begin : g_entry
    logic [c_ptr_w-1:0] offs;
    logic               occ;
    logic [c_pos_w-1:0] pos;

    // Slot is occupied when its distance from the read pointer is below count.
    assign offs = c_ptr_w'(e) - rd_ptr_q;
    assign occ  = ({1'b0, offs} < count_q);
    assign w_hit_vec[e] = occ && (read_req_addr >= head_q[e]) &&
                          ({1'b0, read_req_addr} <
                           ({1'b0, head_q[e]} + (ADDR_WIDTH+1)'(HASH_ISSUE_WIDTH)));
    // Heads are not required to be aligned, so the position is a low-bit difference.
    assign pos = read_req_addr[c_pos_w-1:0] - head_q[e][c_pos_w-1:0];

    // Select the looked-up position's candidate row from this entry.
    always_comb begin
      w_sel_vld[e]  = '0;
      w_sel_hist[e] = '0;
      for (int p = 0; p < HASH_ISSUE_WIDTH; p++) begin
        if (pos == c_pos_w'(p)) begin
          w_sel_vld[e]  = vld_q[e][p*ROW_SIZE +: ROW_SIZE];
          w_sel_hist[e] = hist_q[e][p*c_row_w +: c_row_w];
        end
      end
    end
  end

  // At most one entry hits, so OR-combining the gated slices yields the hit row.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_vld  = '0;
    w_hit_hist = '0;
    for (int e = 0; e < DEPTH; e++) begin
      if (w_hit_vec[e]) begin
        w_hit      = 1'b1;
        w_hit_vld  = w_hit_vld  | w_sel_vld[e];
        w_hit_hist = w_hit_hist | w_sel_hist[e];
      end
    end
  end

  // Lookups during a flush are dropped; gaps and addresses beyond the newest batch stay silent.
  assign w_resp = read_req_valid && !flush && (w_hit || w_stale);

  // Next-state for pointers and count; flush empties the queue without touching data.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (w_push) wr_ptr_d = wr_ptr_q + c_ptr_w'(1);
      if (w_pop)  rd_ptr_d = rd_ptr_q + c_ptr_w'(1);
      if (w_push && !w_pop)      count_d = count_q + c_cnt_w'(1);
      else if (w_pop && !w_push) count_d = count_q - c_cnt_w'(1);
    end
  end

  // Queue control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Batch capture into the slot at the write pointer.
  always_ff @(posedge clk) begin
    if (w_push) begin
      head_q[wr_ptr_q] <= input_head_addr;
      vld_q[wr_ptr_q]  <= input_valid_array;
      hist_q[wr_ptr_q] <= input_history_addr_array;
    end
  end

  // Registered lookup response; payload only updates when a response is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_q <= 1'b0;
      resp_miss_q  <= 1'b0;
      resp_addr_q  <= '0;
      resp_vld_q   <= '0;
      resp_hist_q  <= '0;
    end else begin
      resp_valid_q <= w_resp;
      if (w_resp) begin
        resp_miss_q <= w_stale && !w_hit;
        resp_addr_q <= read_req_addr;
        resp_vld_q  <= w_hit ? w_hit_vld  : '0;
        resp_hist_q <= w_hit ? w_hit_hist : '0;
      end
    end
  end

  assign read_resp_valid         = resp_valid_q;
  assign read_resp_miss          = resp_miss_q;
  assign read_resp_addr          = resp_addr_q;
  assign read_valid_array        = resp_vld_q;
  assign read_history_addr_array = resp_hist_q;
  assign occupancy               = count_q;

endmodule
`default_nettype wire

// File: tb/tb_hash_batch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_hash_batch_queue
// Brief    : Directed self-checking bench for hash_batch_queue (W=4, ROW=8,
//            ADDR=32, DEPTH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hash_batch_queue;

  localparam int W     = 4;
  localparam int ROW   = 8;
  localparam int AW    = 32;
  localparam int DEPTH = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  flush;
  logic                  input_valid;
  logic [AW-1:0]         input_head_addr;
  logic [W*ROW-1:0]      input_valid_array;
  logic [W*ROW*AW-1:0]   input_history_addr_array;
  logic                  input_ready;
  logic                  read_req_valid;
  logic [AW-1:0]         read_req_addr;
  logic                  read_resp_valid;
  logic                  read_resp_miss;
  logic [AW-1:0]         read_resp_addr;
  logic [ROW-1:0]        read_valid_array;
  logic [ROW*AW-1:0]     read_history_addr_array;
  logic [$clog2(DEPTH):0] occupancy;

  int nvec  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  hash_batch_queue #(
    .HASH_ISSUE_WIDTH (W),
    .ROW_SIZE         (ROW),
    .ADDR_WIDTH       (AW),
    .DEPTH            (DEPTH)
  ) dut (
    .clk                      (clk),
    .rst                      (rst),
    .flush                    (flush),
    .input_valid              (input_valid),
    .input_head_addr          (input_head_addr),
    .input_valid_array        (input_valid_array),
    .input_history_addr_array (input_history_addr_array),
    .input_ready              (input_ready),
    .read_req_valid           (read_req_valid),
    .read_req_addr            (read_req_addr),
    .read_resp_valid          (read_resp_valid),
    .read_resp_miss           (read_resp_miss),
    .read_resp_addr           (read_resp_addr),
    .read_valid_array         (read_valid_array),
    .read_history_addr_array  (read_history_addr_array),
    .occupancy                (occupancy)
  );

  // Candidate valid bits for position p of the batch with head h.
  function automatic logic [ROW-1:0] exp_vld(input int h, input int p);
    logic [7:0] t;
    t = 8'(h * 3 + p);
    return t ^ 8'hA5;
  endfunction

  // Candidate addresses for position p of the batch with head h.
  function automatic logic [ROW*AW-1:0] exp_hist(input int h, input int p);
    logic [ROW*AW-1:0] r;
    r = '0;
    for (int c = 0; c < ROW; c++)
      r[c*AW +: AW] = 32'h1000_0000 | 32'(h << 8) | 32'(p << 4) | 32'(c);
    return r;
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    input_valid    = 1'b0;
    read_req_valid = 1'b0;
    flush          = 1'b0;
  endtask

  task automatic set_batch(input int h);
    input_valid     = 1'b1;
    input_head_addr = AW'(h);
    for (int p = 0; p < W; p++) begin
      input_valid_array[p*ROW +: ROW]                  = exp_vld(h, p);
      input_history_addr_array[p*ROW*AW +: ROW*AW]     = exp_hist(h, p);
    end
  endtask

  task automatic push(input int h);
    set_batch(h);
    #1;
    check("push_ready", input_ready, 1);
    step();
    input_valid = 1'b0;
  endtask

  task automatic fill(input int base, input int n);
    for (int i = 0; i < n; i++) push(base + 4 * i);
  endtask

  task automatic lookup(input int a);
    read_req_valid = 1'b1;
    read_req_addr  = AW'(a);
    step();
    read_req_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic chk_hit(input string tag, input int a, input int h, input int p);
    check({tag, "_valid"}, read_resp_valid, 1);
    check({tag, "_miss"},  read_resp_miss, 0);
    check({tag, "_addr"},  read_resp_addr, 256'(a));
    check({tag, "_vld"},   read_valid_array, exp_vld(h, p));
    check({tag, "_hist"},  read_history_addr_array, exp_hist(h, p));
  endtask

  initial begin
    rst = 1'b1;
    idle();
    read_req_addr            = '0;
    input_head_addr          = '0;
    input_valid_array        = '0;
    input_history_addr_array = '0;

    // Reset: a batch offered while in reset is refused.
    step();
    set_batch(0);
    #1;
    check("rst_ready", input_ready, 0);
    step();
    idle();
    check("rst_resp_valid", read_resp_valid, 0);
    check("rst_resp_miss",  read_resp_miss, 0);
    check("rst_resp_addr",  read_resp_addr, 0);
    check("rst_vld",        read_valid_array, 0);
    check("rst_hist",       read_history_addr_array, 0);
    check("rst_occ",        occupancy, 0);
    rst = 1'b0;

    // Lookup on an empty queue is silent.
    lookup(3);
    check("empty_resp", read_resp_valid, 0);

    // Fill heads 0,4,8,12; full queue refuses without a retiring request.
    fill(0, 4);
    check("full_occ", occupancy, 4);
    #1;
    check("full_ready", input_ready, 0);
    set_batch(40);
    #1;
    check("full_offer_ready", input_ready, 0);
    step();
    input_valid = 1'b0;
    check("full_no_capture_occ", occupancy, 4);

    // Every position of the oldest batch, none of which retires it.
    for (int a = 0; a < 4; a++) begin
      lookup(a);
      chk_hit("sweep", a, 0, a);
    end
    check("sweep_occ", occupancy, 4);

    // Addr 9: position 1 of head 8; also passes head 0, which retires.
    lookup(9);
    chk_hit("hit9", 9, 8, 1);
    check("hit9_occ", occupancy, 3);

    // Reset together with a hitting request discards it and all entries.
    rst            = 1'b1;
    read_req_valid = 1'b1;
    read_req_addr  = AW'(9);
    step();
    read_req_valid = 1'b0;
    check("midrst_resp", read_resp_valid, 0);
    check("midrst_occ",  occupancy, 0);
    rst = 1'b0;

    // Retire at full with a concurrent push of head 16.
    fill(0, 4);
    read_req_valid = 1'b1;
    read_req_addr  = AW'(4);
    set_batch(16);
    #1;
    check("retire_ready", input_ready, 1);
    step();
    idle();
    chk_hit("retire", 4, 4, 0);
    check("retire_occ", occupancy, 4);

    // Stale: below the oldest head (now 4).
    lookup(2);
    check("stale_valid", read_resp_valid, 1);
    check("stale_miss",  read_resp_miss, 1);
    check("stale_addr",  read_resp_addr, 2);
    check("stale_vld",   read_valid_array, 0);
    check("stale_hist",  read_history_addr_array, 0);
    check("stale_occ",   occupancy, 4);

    // Hit on the wrapped-around newest batch while head 4 retires.
    lookup(17);
    chk_hit("wrap", 17, 16, 1);
    check("wrap_occ", occupancy, 3);
    lookup(12);
    chk_hit("h12", 12, 12, 0);
    check("h12_occ", occupancy, 2);

    // Gap: heads 0 and 8, addr 5 is silent but retires head 0.
    do_reset();
    push(0);
    push(8);
    check("gap_occ0", occupancy, 2);
    lookup(5);
    check("gap_resp", read_resp_valid, 0);
    check("gap_occ1", occupancy, 1);

    // Beyond newest: addr 20 silent, retires head 0, head 8 remains.
    do_reset();
    push(0);
    push(8);
    lookup(20);
    check("beyond_resp", read_resp_valid, 0);
    check("beyond_occ",  occupancy, 1);
    lookup(9);
    chk_hit("after_beyond", 9, 8, 1);

    // Flush with three entries and a hitting request.
    do_reset();
    fill(0, 3);
    flush          = 1'b1;
    read_req_valid = 1'b1;
    read_req_addr  = AW'(5);
    set_batch(12);
    #1;
    check("flush_ready", input_ready, 0);
    step();
    idle();
    check("flush_resp", read_resp_valid, 0);
    check("flush_occ",  occupancy, 0);
    lookup(5);
    check("postflush_resp", read_resp_valid, 0);
    push(100);
    lookup(101);
    chk_hit("postflush_hit", 101, 100, 1);
    check("postflush_occ", occupancy, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
`default_nettype wire
